bullcow_turn_ctrl: RTL and testbench

Turn sequencer for the two-player Bulls & Cows game. It conditions the `enter` button and captures each player's secret from `SW`. It alternates guesses between J1 and J2 and drives a shared bull/cow comparison datapath through a req/done handshake. It also keeps per-player bull/cow results and match points for the display/LED block.

---
 rtl/bullcow_turn_ctrl_if.sv | 20 ++
 rtl/bullcow_turn_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bullcow_turn_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bullcow_turn_ctrl_if.sv
// Handshake between the Bulls & Cows turn sequencer and the shared scoring datapath.
// The sequencer is the master: it raises cmp_req with a secret/guess pair and waits for cmp_done.
interface bullcow_turn_ctrl_if;
    logic        cmp_req;
    logic [15:0] cmp_secret;
    logic [15:0] cmp_guess;
    logic        cmp_done;
    logic [2:0]  cmp_bulls;
    logic [2:0]  cmp_cows;

    modport master (
        output cmp_req, cmp_secret, cmp_guess,
        input  cmp_done, cmp_bulls, cmp_cows
    );

    modport slave (
        input  cmp_req, cmp_secret, cmp_guess,
        output cmp_done, cmp_bulls, cmp_cows
    );
endinterface

// File: rtl/bullcow_turn_ctrl.sv
// Bulls & Cows turn sequencer: enter conditioning, secret capture, alternating guesses, scoring handshake.
// Optional enter debounce is compiled in with the BULLCOW_DEBOUNCE_EN macro.
module bullcow_turn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int POINTS_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enter,
    input  logic [15:0]          SW,
    bullcow_turn_ctrl_if.master  cmp,
    output logic [2:0]           game_state,
    output logic [2:0]           J1_bull_count,
    output logic [2:0]           J1_cow_count,
    output logic [2:0]           J2_bull_count,
    output logic [2:0]           J2_cow_count,
    output logic [POINTS_W-1:0]  J1_points,
    output logic [POINTS_W-1:0]  J2_points,
    output logic                 J1_guess_confirmed,
    output logic                 J2_guess_confirmed,
    output logic                 input_error
);

    typedef enum logic [2:0] {
        SET_J1   = 3'd0,
        SET_J2   = 3'd1,
        GUESS_J1 = 3'd2,
        WAIT_J1  = 3'd3,
        GUESS_J2 = 3'd4,
        WAIT_J2  = 3'd5,
        WIN_J1   = 3'd6,
        WIN_J2   = 3'd7
    } state_t;

    state_t      state;
    logic [15:0] secret_j1;
    logic [15:0] secret_j2;
    logic        pts_pend;

    logic sync1, sync2;
    logic enter_lvl;
    logic enter_prev;
    logic enter_pulse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= enter;
            sync2 <= sync1;
        end
    end

`ifdef BULLCOW_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [DB_W-1:0] db_cnt;
    logic            enter_db;

    // A new synchronized level is adopted only after it has been seen for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt   <= '0;
            enter_db <= 1'b0;
        end else if (sync2 == enter_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            enter_db <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign enter_lvl = enter_db;
`else
    logic unused_db_cfg;
    assign unused_db_cfg = ^DEBOUNCE_CYCLES;
    assign enter_lvl     = sync2;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) enter_prev <= 1'b0;
        else        enter_prev <= enter_lvl;
    end

    assign enter_pulse = enter_lvl & ~enter_prev;

    // All four digits must be pairwise distinct.
    logic word_ok;
    always_comb begin
        word_ok = (SW[15:12] != SW[11:8]) && (SW[15:12] != SW[7:4]) && (SW[15:12] != SW[3:0]) &&
                  (SW[11:8]  != SW[7:4])  && (SW[11:8]  != SW[3:0]) && (SW[7:4]   != SW[3:0]);
    end

    assign game_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= SET_J1;
            secret_j1          <= '0;
            secret_j2          <= '0;
            pts_pend           <= 1'b0;
            cmp.cmp_req        <= 1'b0;
            cmp.cmp_secret     <= '0;
            cmp.cmp_guess      <= '0;
            J1_bull_count      <= '0;
            J1_cow_count       <= '0;
            J2_bull_count      <= '0;
            J2_cow_count       <= '0;
            J1_points          <= '0;
            J2_points          <= '0;
            J1_guess_confirmed <= 1'b0;
            J2_guess_confirmed <= 1'b0;
            input_error        <= 1'b0;
        end else begin
            J1_guess_confirmed <= 1'b0;
            J2_guess_confirmed <= 1'b0;
            input_error        <= 1'b0;
            case (state)
                SET_J1: if (enter_pulse) begin
                    if (word_ok) begin
                        secret_j1 <= SW;
                        state     <= SET_J2;
                    end else input_error <= 1'b1;
                end
                SET_J2: if (enter_pulse) begin
                    if (word_ok) begin
                        secret_j2 <= SW;
                        state     <= GUESS_J1;
                    end else input_error <= 1'b1;
                end
                GUESS_J1: if (enter_pulse) begin
                    if (word_ok) begin
                        cmp.cmp_req        <= 1'b1;
                        cmp.cmp_guess      <= SW;
                        cmp.cmp_secret     <= secret_j2;
                        J1_guess_confirmed <= 1'b1;
                        state              <= WAIT_J1;
                    end else input_error <= 1'b1;
                end
                GUESS_J2: if (enter_pulse) begin
                    if (word_ok) begin
                        cmp.cmp_req        <= 1'b1;
                        cmp.cmp_guess      <= SW;
                        cmp.cmp_secret     <= secret_j1;
                        J2_guess_confirmed <= 1'b1;
                        state              <= WAIT_J2;
                    end else input_error <= 1'b1;
                end
                WAIT_J1: if (cmp.cmp_done) begin
                    cmp.cmp_req    <= 1'b0;
                    cmp.cmp_secret <= '0;
                    cmp.cmp_guess  <= '0;
                    J1_bull_count  <= cmp.cmp_bulls;
                    J1_cow_count   <= cmp.cmp_cows;
                    if (cmp.cmp_bulls == 3'd4) begin
                        state    <= WIN_J1;
                        pts_pend <= 1'b1;
                    end else state <= GUESS_J2;
                end
                WAIT_J2: if (cmp.cmp_done) begin
                    cmp.cmp_req    <= 1'b0;
                    cmp.cmp_secret <= '0;
                    cmp.cmp_guess  <= '0;
                    J2_bull_count  <= cmp.cmp_bulls;
                    J2_cow_count   <= cmp.cmp_cows;
                    if (cmp.cmp_bulls == 3'd4) begin
                        state    <= WIN_J2;
                        pts_pend <= 1'b1;
                    end else state <= GUESS_J1;
                end
                WIN_J1, WIN_J2: begin
                    // Points step once in the first WIN cycle and hold at all-ones.
                    if (pts_pend) begin
                        pts_pend <= 1'b0;
                        if (state == WIN_J1 && J1_points != '1) J1_points <= J1_points + 1'b1;
                        if (state == WIN_J2 && J2_points != '1) J2_points <= J2_points + 1'b1;
                    end
                    if (enter_pulse) begin
                        state         <= SET_J1;
                        J1_bull_count <= '0;
                        J1_cow_count  <= '0;
                        J2_bull_count <= '0;
                        J2_cow_count  <= '0;
                    end
                end
                default: state <= SET_J1;
            endcase
        end
    end

endmodule

// File: tb/tb_bullcow_turn_ctrl.sv
// Bench for bullcow_turn_ctrl: the bench plays the scoring datapath and checks each request
// against a queue of expected secret/guess pairs pushed when the guess is keyed in.
module tb_bullcow_turn_ctrl;

    localparam int PW = 2;
    localparam int DB = 8;
`ifdef BULLCOW_DEBOUNCE_EN
    localparam int HOLD = DB + 6;
`else
    localparam int HOLD = 4;
`endif

    typedef struct {
        logic [15:0] sec;
        logic [15:0] gs;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enter = 1'b0;
    logic [15:0]   SW = '0;
    logic [2:0]    game_state;
    logic [2:0]    J1_bull_count, J1_cow_count, J2_bull_count, J2_cow_count;
    logic [PW-1:0] J1_points, J2_points;
    logic          J1_guess_confirmed, J2_guess_confirmed, input_error;

    bullcow_turn_ctrl_if cmp();

    bullcow_turn_ctrl #(.DEBOUNCE_CYCLES(DB), .POINTS_W(PW)) dut (
        .clock(clock), .reset(reset), .enter(enter), .SW(SW), .cmp(cmp),
        .game_state(game_state),
        .J1_bull_count(J1_bull_count), .J1_cow_count(J1_cow_count),
        .J2_bull_count(J2_bull_count), .J2_cow_count(J2_cow_count),
        .J1_points(J1_points), .J2_points(J2_points),
        .J1_guess_confirmed(J1_guess_confirmed), .J2_guess_confirmed(J2_guess_confirmed),
        .input_error(input_error)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   err_n = 0, c1_n = 0, c2_n = 0;
    exp_t sb[$];

    always @(negedge clock) begin
        err_n <= err_n + int'(input_error);
        c1_n  <= c1_n + int'(J1_guess_confirmed);
        c2_n  <= c2_n + int'(J2_guess_confirmed);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                  output logic [2:0] b, output logic [2:0] c);
        b = 0;
        c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (s[i*4 +: 4] == g[j*4 +: 4]) begin
                    if (i == j) b = b + 1'b1;
                    else        c = c + 1'b1;
                end
    endfunction

    task automatic press(input logic [15:0] w);
        SW = w;
        enter = 1'b1;
        repeat (HOLD) @(negedge clock);
        enter = 1'b0;
        repeat (HOLD) @(negedge clock);
    endtask

    task automatic guess(input logic [15:0] sec, input logic [15:0] g);
        exp_t e;
        e.sec = sec;
        e.gs  = g;
        sb.push_back(e);
        press(g);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s);
        for (int n = 0; n < 60 && game_state !== s; n++) @(negedge clock);
        chk(tag, 32'(game_state), 32'(s));
    endtask

    // Datapath model: answer the pending request with the expected pair's score.
    task automatic serve();
        exp_t e;
        logic [2:0] b, c;
        for (int n = 0; n < 60 && cmp.cmp_req !== 1'b1; n++) @(negedge clock);
        chk("req_seen", 32'(cmp.cmp_req), 32'd1);
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (cmp.cmp_req !== 1'b1 || sb.size() == 0) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        chk("cmp_secret", 32'(cmp.cmp_secret), 32'(e.sec));
        chk("cmp_guess", 32'(cmp.cmp_guess), 32'(e.gs));
        score(e.sec, e.gs, b, c);
        cmp.cmp_bulls = b;
        cmp.cmp_cows  = c;
        cmp.cmp_done  = 1'b1;
        @(negedge clock);
        cmp.cmp_done  = 1'b0;
        chk("req_drop", 32'(cmp.cmp_req), 32'd0);
        chk("secret_idle", 32'(cmp.cmp_secret), 32'd0);
    endtask

    initial begin
        cmp.cmp_done  = 1'b0;
        cmp.cmp_bulls = '0;
        cmp.cmp_cows  = '0;
        repeat (3) @(negedge clock);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_req", 32'(cmp.cmp_req), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_pts", 32'({J1_points, J2_points}), 32'd0);
        chk("rst_counts", 32'({J1_bull_count, J1_cow_count, J2_bull_count, J2_cow_count}), 32'd0);

        // Repeated digit rejected in SET_J1
        press(16'h1123);
        chk("err_1123", 32'(err_n), 32'd1);
        chk("st_after_bad", 32'(game_state), 32'd0);

        press(16'h1234);
        wait_state("st_set_j2", 3'd1);
        press(16'h5678);
        wait_state("st_guess_j1", 3'd2);
        chk("err_secrets", 32'(err_n), 32'd1);

        press(16'h1111);
        chk("err_guess", 32'(err_n), 32'd2);
        chk("st_bad_guess", 32'(game_state), 32'd2);

        guess(16'h5678, 16'h5687);
        chk("j1_confirm", 32'(c1_n), 32'd1);
        serve();
        wait_state("st_guess_j2", 3'd4);
        chk("j1_bulls", 32'(J1_bull_count), 32'd2);
        chk("j1_cows", 32'(J1_cow_count), 32'd2);

        // J2 guess is checked against the first secret, proving 1123 never overwrote it
        guess(16'h1234, 16'h1234);
        chk("j2_confirm", 32'(c2_n), 32'd1);
        serve();
        wait_state("st_win_j2", 3'd7);
        @(negedge clock);
        chk("j2_pts_1", 32'(J2_points), 32'd1);
        chk("j2_bulls", 32'(J2_bull_count), 32'd4);
        press(16'h0000);
        wait_state("st_restart", 3'd0);
        chk("clr_counts", 32'({J1_bull_count, J1_cow_count, J2_bull_count, J2_cow_count}), 32'd0);
        chk("j2_pts_kept", 32'(J2_points), 32'd1);

        // Four J1 wins against a 2-bit counter
        for (int k = 1; k <= 4; k++) begin
            press(16'h1234);
            press(16'h5678);
            guess(16'h5678, 16'h5678);
            serve();
            wait_state("st_win_j1", 3'd6);
            @(negedge clock);
            chk($sformatf("j1_pts_%0d", k), 32'(J1_points), 32'(k > 3 ? 3 : k));
            press(16'h0000);
            wait_state("st_back", 3'd0);
        end
        chk("j2_pts_final", 32'(J2_points), 32'd1);

        // Asynchronous reset mid-request, then a stray cmp_done
        press(16'h1234);
        press(16'h5678);
        sb.delete();
        press(16'h5687);
        chk("st_wait_j1", 32'(game_state), 32'd3);
        chk("req_up", 32'(cmp.cmp_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_req", 32'(cmp.cmp_req), 32'd0);
        chk("async_state", 32'(game_state), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cmp.cmp_bulls = 3'd4;
        cmp.cmp_done  = 1'b1;
        @(negedge clock);
        cmp.cmp_done  = 1'b0;
        @(negedge clock);
        chk("late_done_st", 32'(game_state), 32'd0);
        chk("late_done_out", 32'({cmp.cmp_req, J1_points, J2_points, J1_bull_count, J2_bull_count}), 32'd0);
        chk("late_done_cmp", 32'(cmp.cmp_guess | cmp.cmp_secret), 32'd0);

`ifdef BULLCOW_DEBOUNCE_EN
        SW = 16'h1234;
        enter = 1'b1;
        repeat (5) @(negedge clock);
        enter = 1'b0;
        repeat (3 * DB) @(negedge clock);
        chk("glitch_state", 32'(game_state), 32'd0);
`endif

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
